// File: rtl/alu_pkg.sv
// +----------------------------------------------------------------------------+
// | alu_pkg : widths, opcodes, status-register indices and FSM states shared    |
// |           by the execute stage and its ALU core.                            |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

    localparam int WORD_W = 20;
    localparam int HALF_W = 10;
    localparam int REG_AW = 4;
    localparam int OP_W   = 5;
    localparam int SR_W   = 3;

    localparam int SR_Z = 0;
    localparam int SR_S = 1;
    localparam int SR_C = 2;

    typedef enum logic [OP_W-1:0] {
        OP_NOT   = 5'd0,
        OP_AND   = 5'd1,
        OP_OR    = 5'd2,
        OP_XOR   = 5'd3,
        OP_SHL   = 5'd4,
        OP_SHR   = 5'd5,
        OP_ROTL  = 5'd6,
        OP_ROTR  = 5'd7,
        OP_SWAP  = 5'd8,
        OP_INC   = 5'd9,
        OP_DEC   = 5'd10,
        OP_ADD   = 5'd11,
        OP_ADC   = 5'd12,
        OP_SUB   = 5'd13,
        OP_SBC   = 5'd14,
        OP_EQ    = 5'd15,
        OP_GT    = 5'd16,
        OP_LT    = 5'd17,
        OP_GE    = 5'd18,
        OP_LE    = 5'd19,
        OP_LDSR  = 5'd20,
        OP_XORSR = 5'd21
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB_A = 2'd2,
        ST_WB_B = 2'd3
    } state_e;

    function automatic logic [WORD_W-1:0] active_mask(input logic mode);
        return mode ? {WORD_W{1'b1}}
                    : {{(WORD_W-HALF_W){1'b0}}, {HALF_W{1'b1}}};
    endfunction

    function automatic logic active_msb(input logic mode, input logic [WORD_W-1:0] x);
        logic [WORD_W-1:0] sel;
        sel = mode ? {1'b1, {(WORD_W-1){1'b0}}}
                   : {{(WORD_W-HALF_W){1'b0}}, 1'b1, {(HALF_W-1){1'b0}}};
        return |(x & sel);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_core.sv
// +----------------------------------------------------------------------------+
// | alu_core : combinational ALU - results, next status register and number   |
// |            of write-backs for one operation.                               |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_core
    import alu_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic              mode,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic [SR_W-1:0]   sr_in,
    output logic [WORD_W-1:0] res_a,
    output logic [WORD_W-1:0] res_b,
    output logic [SR_W-1:0]   sr_next,
    output logic [1:0]        wb_cnt
);

    localparam int PAD_W = WORD_W - HALF_W;

    logic [WORD_W-1:0] w_mask;
    logic [WORD_W-1:0] w_am;
    logic [WORD_W-1:0] w_bm;
    logic [WORD_W-1:0] w_rhs;
    logic              w_cin;
    logic [WORD_W:0]   w_sum;
    logic [WORD_W:0]   w_diff;
    logic              w_carry;
    logic              w_borrow;
    logic [WORD_W-1:0] w_shl;
    logic [WORD_W-1:0] w_shr;
    logic [WORD_W-1:0] w_rotl;
    logic [WORD_W-1:0] w_rotr;
    logic              w_old_msb;
    logic              w_eq;
    logic              w_lt;
    logic [WORD_W-1:0] w_res;
    logic              w_c_new;
    logic              w_upd_zs;

    assign w_mask = active_mask(mode);
    assign w_am   = a & w_mask;
    assign w_bm   = b & w_mask;

    // One shared adder/subtractor: INC/DEC use a constant 1, ADC/SBC add SR.C.
    assign w_rhs = (op == OP_INC || op == OP_DEC) ? {{(WORD_W-1){1'b0}}, 1'b1} : w_bm;
    assign w_cin = (op == OP_ADC || op == OP_SBC) ? sr_in[SR_C] : 1'b0;

    assign w_sum  = {1'b0, w_am} + {1'b0, w_rhs} + {{WORD_W{1'b0}}, w_cin};
    assign w_diff = {1'b0, w_am} - {1'b0, w_rhs} - {{WORD_W{1'b0}}, w_cin};

    assign w_carry  = mode ? w_sum[WORD_W] : w_sum[HALF_W];
    // Operands are zero-extended, so any underflow wraps into the top bit.
    assign w_borrow = w_diff[WORD_W];

    assign w_shl     = (w_am << 1) & w_mask;
    assign w_shr     = w_am >> 1;
    assign w_old_msb = active_msb(mode, w_am);

    assign w_rotl = mode ? {a[WORD_W-2:0], a[WORD_W-1]}
                         : {{PAD_W{1'b0}}, a[HALF_W-2:0], a[HALF_W-1]};
    assign w_rotr = mode ? {a[0], a[WORD_W-1:1]}
                         : {{PAD_W{1'b0}}, a[0], a[HALF_W-1:1]};

    assign w_eq = (w_am == w_bm);
    assign w_lt = (w_am < w_bm);

    always_comb begin
        res_a    = '0;
        res_b    = '0;
        sr_next  = sr_in;
        wb_cnt   = 2'd0;
        w_res    = '0;
        w_c_new  = sr_in[SR_C];
        w_upd_zs = 1'b0;

        case (op)
            OP_NOT: begin
                w_res = ~w_am & w_mask;  w_c_new = 1'b0;  w_upd_zs = 1'b1;
            end
            OP_AND: begin
                w_res = w_am & w_bm;     w_c_new = 1'b0;  w_upd_zs = 1'b1;
            end
            OP_OR: begin
                w_res = w_am | w_bm;     w_c_new = 1'b0;  w_upd_zs = 1'b1;
            end
            OP_XOR: begin
                w_res = w_am ^ w_bm;     w_c_new = 1'b0;  w_upd_zs = 1'b1;
            end
            OP_SHL: begin
                w_res = w_shl;           w_c_new = w_old_msb;  w_upd_zs = 1'b1;
            end
            OP_SHR: begin
                w_res = w_shr;           w_c_new = a[0];       w_upd_zs = 1'b1;
            end
            OP_ROTL: begin
                w_res = w_rotl;          w_upd_zs = 1'b1;
            end
            OP_ROTR: begin
                w_res = w_rotr;          w_upd_zs = 1'b1;
            end
            OP_INC, OP_ADD, OP_ADC: begin
                w_res = w_sum[WORD_W-1:0] & w_mask;  w_c_new = w_carry;  w_upd_zs = 1'b1;
            end
            OP_DEC, OP_SUB, OP_SBC: begin
                w_res = w_diff[WORD_W-1:0] & w_mask; w_c_new = w_borrow; w_upd_zs = 1'b1;
            end
            OP_SWAP: begin
                res_a  = w_bm;
                res_b  = w_am;
                wb_cnt = 2'd2;
            end
            OP_EQ, OP_GT, OP_LT, OP_GE, OP_LE: begin
                sr_next[SR_Z] = w_eq;
                sr_next[SR_S] = w_lt;
                sr_next[SR_C] = 1'b0;
            end
            OP_LDSR: begin
                sr_next = a[SR_W-1:0];
            end
            OP_XORSR: begin
                sr_next = sr_in ^ a[SR_W-1:0];
            end
            default: begin
                sr_next = sr_in;
            end
        endcase

        if (w_upd_zs) begin
            res_a         = w_res;
            wb_cnt        = 2'd1;
            sr_next[SR_Z] = (w_res == '0);
            sr_next[SR_S] = active_msb(mode, w_res);
            sr_next[SR_C] = w_c_new;
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_exec_stage.sv
// +----------------------------------------------------------------------------+
// | alu_exec_stage : execute-stage controller - accepts one op, computes it,  |
// |                  updates SR and presents up to two register write-backs.  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_exec_stage
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic              in_mode,
    input  logic [WORD_W-1:0] in_a,
    input  logic [WORD_W-1:0] in_b,
    input  logic [REG_AW-1:0] in_rd_a,
    input  logic [REG_AW-1:0] in_rd_b,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [REG_AW-1:0] wb_addr,
    output logic [WORD_W-1:0] wb_data,
    output logic [SR_W-1:0]   sr_out
);

    state_e            r_state;
    logic [OP_W-1:0]   r_op;
    logic              r_mode;
    logic [WORD_W-1:0] r_a;
    logic [WORD_W-1:0] r_b;
    logic [REG_AW-1:0] r_rd_a;
    logic [REG_AW-1:0] r_rd_b;
    logic [WORD_W-1:0] r_res_b;
    logic              r_second;
    logic              r_wb_valid;
    logic [REG_AW-1:0] r_wb_addr;
    logic [WORD_W-1:0] r_wb_data;
    logic [SR_W-1:0]   r_sr;

    logic [WORD_W-1:0] w_res_a;
    logic [WORD_W-1:0] w_res_b;
    logic [SR_W-1:0]   w_sr_next;
    logic [1:0]        w_wb_cnt;

    alu_core u_alu_core (
        .op      (r_op),
        .mode    (r_mode),
        .a       (r_a),
        .b       (r_b),
        .sr_in   (r_sr),
        .res_a   (w_res_a),
        .res_b   (w_res_b),
        .sr_next (w_sr_next),
        .wb_cnt  (w_wb_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_op       <= '0;
            r_mode     <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_rd_a     <= '0;
            r_rd_b     <= '0;
            r_res_b    <= '0;
            r_second   <= 1'b0;
            r_wb_valid <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
            r_sr       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_op    <= in_op;
                        r_mode  <= in_mode;
                        r_a     <= in_a;
                        r_b     <= in_b;
                        r_rd_a  <= in_rd_a;
                        r_rd_b  <= in_rd_b;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_sr     <= w_sr_next;
                    r_res_b  <= w_res_b;
                    r_second <= (w_wb_cnt == 2'd2);
                    if (w_wb_cnt != 2'd0) begin
                        r_wb_valid <= 1'b1;
                        r_wb_addr  <= r_rd_a;
                        r_wb_data  <= w_res_a;
                        r_state    <= ST_WB_A;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WB_A: begin
                    if (wb_ready) begin
                        // SWAP keeps wb_valid high and reloads the second result.
                        if (r_second) begin
                            r_wb_addr <= r_rd_b;
                            r_wb_data <= r_res_b;
                            r_state   <= ST_WB_B;
                        end else begin
                            r_wb_valid <= 1'b0;
                            r_state    <= ST_IDLE;
                        end
                    end
                end
                ST_WB_B: begin
                    if (wb_ready) begin
                        r_wb_valid <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_wb_valid <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready = rst_n && (r_state == ST_IDLE);
    assign wb_valid = r_wb_valid;
    assign wb_addr  = r_wb_addr;
    assign wb_data  = r_wb_data;
    assign sr_out   = r_sr;

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_stage.sv
// +----------------------------------------------------------------------------+
// | tb_alu_exec_stage : directed and random ops against an arithmetic model.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_alu_exec_stage;
    import alu_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_op;
    logic              in_mode;
    logic [19:0]       in_a;
    logic [19:0]       in_b;
    logic [3:0]        in_rd_a;
    logic [3:0]        in_rd_b;
    logic              wb_valid;
    logic              wb_ready;
    logic [3:0]        wb_addr;
    logic [19:0]       wb_data;
    logic [2:0]        sr_out;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [2:0] m_sr;

    always #5 clk = ~clk;

    alu_exec_stage dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_mode  (in_mode),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_rd_a  (in_rd_a),
        .in_rd_b  (in_rd_b),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .sr_out   (sr_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: the operation expressed as modular integer arithmetic on 2**W.
    function automatic void model(input int op, input bit mode, input longint ai, input longint bi,
                                  input logic [2:0] sr, output longint ra, output longint rb,
                                  output logic [2:0] srn, output int nwb);
        longint m, half, a, b, r, t, c;
        bit nc, upd;
        m    = mode ? 64'sd1048576 : 64'sd1024;
        half = m / 2;
        a    = ai % m;
        b    = bi % m;
        c    = sr[2] ? 1 : 0;
        ra = 0; rb = 0; srn = sr; nwb = 0; r = 0; t = 0; nc = 1'b0; upd = 1'b1;
        case (op)
            0:  r = m - 1 - a;
            1:  r = a & b;
            2:  r = a | b;
            3:  r = a ^ b;
            4:  begin r = (2 * a) % m; nc = (a >= half); end
            5:  begin r = a / 2; nc = ((a % 2) == 1); end
            6:  begin r = (2 * a) % m + a / half; nc = sr[2]; end
            7:  begin r = a / 2 + (a % 2) * half; nc = sr[2]; end
            8:  begin ra = b; rb = a; nwb = 2; upd = 1'b0; end
            9:  begin t = a + 1; r = t % m; nc = (t >= m); end
            10: begin r = (a + m - 1) % m; nc = (a < 1); end
            11: begin t = a + b; r = t % m; nc = (t >= m); end
            12: begin t = a + b + c; r = t % m; nc = (t >= m); end
            13: begin r = (a - b + m) % m; nc = (a < b); end
            14: begin r = (a - b - c + 2 * m) % m; nc = (a < b + c); end
            15, 16, 17, 18, 19: begin srn = {1'b0, a < b, a == b}; upd = 1'b0; end
            20: begin srn = 3'(a & 7); upd = 1'b0; end
            21: begin srn = sr ^ 3'(a & 7); upd = 1'b0; end
            default: upd = 1'b0;
        endcase
        if (upd) begin
            ra  = r;
            nwb = 1;
            srn = {nc, r >= half, r == 0};
        end
    endfunction

    task automatic run_op(input int op, input bit mode, input logic [19:0] a, input logic [19:0] b,
                          input logic [3:0] rda, input logic [3:0] rdb, input int stall, input string tag);
        longint     ea, eb;
        logic [2:0] esr;
        int         nwb;
        logic [3:0] x_addr;
        logic [19:0] x_data;
        model(op, mode, a, b, m_sr, ea, eb, esr, nwb);
        @(negedge clk);
        check({tag, "/ready_idle"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_op = op[4:0]; in_mode = mode;
        in_a = a; in_b = b; in_rd_a = rda; in_rd_b = rdb;
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_op = 5'($urandom); in_mode = 1'($urandom);
        in_a = 20'($urandom); in_b = 20'($urandom);
        in_rd_a = 4'($urandom); in_rd_b = 4'($urandom);
        @(negedge clk);
        check({tag, "/exec_busy"}, {30'd0, in_ready, wb_valid}, 32'd0);
        @(posedge clk);
        m_sr = esr;
        for (int w = 0; w < nwb; w++) begin
            x_addr = (w == 0) ? rda : rdb;
            x_data = (w == 0) ? 20'(ea) : 20'(eb);
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                check({tag, "/wb_stall"}, {4'd0, in_ready, sr_out, wb_valid, x_addr, x_data} ^ 32'd0,
                      {4'd0, 1'b0, m_sr, 1'b1, x_addr, x_data});
                check({tag, "/wb_stall_obs"}, {7'd0, wb_valid, wb_addr, wb_data},
                      {7'd0, 1'b1, x_addr, x_data});
                @(posedge clk);
            end
            @(negedge clk);
            check({tag, "/wb"}, {3'd0, in_ready, sr_out, wb_valid, wb_addr, wb_data},
                  {3'd0, 1'b0, m_sr, 1'b1, x_addr, x_data});
            wb_ready = 1'b1;
            @(posedge clk);
            #1;
            wb_ready = 1'b0;
        end
        @(negedge clk);
        check({tag, "/done"}, {27'd0, in_ready, wb_valid, sr_out}, {27'd0, 1'b1, 1'b0, m_sr});
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_mode = 1'b0;
        in_a = '0; in_b = '0; in_rd_a = '0; in_rd_b = '0; wb_ready = 1'b0;
        m_sr = 3'b000;

        #12;
        check("reset_outputs", {4'd0, in_ready, wb_valid, wb_addr, wb_data, sr_out},
              32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", {30'd0, in_ready, wb_valid}, 32'd2);

        run_op(11, 1'b1, 20'hFFFFF, 20'h00001, 4'd3, 4'd0, 0, "add_ovf");
        check("add_ovf_sr", 32'(sr_out), 32'b101);
        run_op(12, 1'b1, 20'h00001, 20'h00001, 4'd4, 4'd0, 1, "adc");
        check("adc_sr", 32'(sr_out), 32'b000);
        run_op(13, 1'b0, 20'h00003, 20'h00005, 4'd5, 4'd0, 0, "sub_half");
        check("sub_half_sr", 32'(sr_out), 32'b110);
        run_op(8, 1'b1, 20'h12345, 20'h0ABCD, 4'd1, 4'd2, 3, "swap");
        check("swap_sr", 32'(sr_out), 32'b110);
        run_op(20, 1'b1, 20'h00005, 20'h0, 4'd6, 4'd0, 0, "ldsr");
        check("ldsr_sr", 32'(sr_out), 32'b101);
        run_op(21, 1'b1, 20'h00003, 20'h0, 4'd6, 4'd0, 0, "xorsr");
        check("xorsr_sr", 32'(sr_out), 32'b110);

        for (int i = 0; i < 160; i++) begin
            run_op(int'($urandom_range(0, 31)), 1'($urandom), 20'($urandom), 20'($urandom),
                   4'($urandom), 4'($urandom), int'($urandom_range(0, 2)), "rand");
        end

        // Reset while a write-back is being offered.
        @(negedge clk);
        in_valid = 1'b1; in_op = 5'd11; in_mode = 1'b1;
        in_a = 20'h00005; in_b = 20'h00006; in_rd_a = 4'd7; in_rd_b = 4'd0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_pre_wb", {7'd0, wb_valid, wb_addr, wb_data}, {7'd0, 1'b1, 4'd7, 20'h0000B});
        #2 rst_n = 1'b0;
        #1;
        check("rst_async", {4'd0, in_ready, wb_valid, wb_addr, wb_data, sr_out}, 32'd0);
        m_sr = 3'b000;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_release", {29'd0, in_ready, wb_valid, 1'b0}, {29'd0, 1'b1, 1'b0, 1'b0});
        run_op(9, 1'b0, 20'h003FF, 20'h0, 4'd9, 4'd0, 1, "inc_after_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_exec_stage.md
# alu_exec_stage

Execute-stage controller that sits directly downstream of operand fetch and wraps the ALU datapath. It accepts one operation per valid/ready handshake, computes it in one cycle, and updates the 3-bit status register (Z, S, C). It then returns one result to the register-file write port, or two results for SWAP, using a second valid/ready handshake. Compare and status-register operations update flags only and issue no write-back.

## Interface
- WORD_W, 20, full-word width
- HALF_W, 10, half-word width (mode 0)
- REG_AW, 4, register-file address width
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operation offered
- in_ready  out  1  stage can accept; high only in IDLE with rst_n high
- in_op  in  5  opcode (alu_pkg)
- in_mode  in  1  1 = full word, 0 = half word
- in_a, in_b  in  WORD_W  operands
- in_rd_a, in_rd_b  in  REG_AW  destinations (rd_b used by SWAP only)
- wb_valid  out  1  write-back offered
- wb_ready  in  1  register file accepts
- wb_addr  out  REG_AW  write-back destination
- wb_data  out  WORD_W  write-back value
- sr_out  out  3  status register: [0]=Z, [1]=S, [2]=C

## Operation
- **States:** IDLE → EXEC → WB_A → (WB_B) → IDLE.
- **IDLE:** in_ready=1. If in_valid, latch op, mode, a, b, rd_a, rd_b, then go to EXEC.
- **EXEC (always 1 cycle):** register the alu_core result and update SR.
  - Write-back ops go to WB_A.
  - All other ops (compare, LDSR, XORSR, undefined) return to IDLE.
- **WB_A:** wb_valid=1 with {rd_a, res_a}. On wb_ready, SWAP goes to WB_B; all others go to IDLE.
- **WB_B:** wb_valid=1 with {rd_b, res_b}. On wb_ready, go to IDLE.
- **Active width:**
  - Mode 0 operates on bits [9:0]; result bits [19:10] are forced to 0.
  - MSB means bit 19 in mode 1 and bit 9 in mode 0.
- **Flags (Z/S):** Z = (active result == 0); S = active MSB.
- **Flag updates per op class:**
  - NOT/AND/OR/XOR: Z,S updated; C←0.
  - SHL (a<<1): C←old MSB. SHR (a>>1): C←old bit 0.
  - ROTL/ROTR: Z,S updated; C unchanged.
  - INC/ADD: C = carry-out of the active width.
  - ADC: ADD with carry-in = SR.C.
  - DEC/SUB: C = borrow, i.e. set when a < b (unsigned, active width).
  - SBC: SUB also subtracting SR.C.
  - EQ/GT/LT/GE/LE: Z←(a==b), S←(a<b) unsigned over the active width, C←0. No write-back.
  - SWAP: res_a=b, res_b=a; flags unchanged.
  - LDSR: SR←a[2:0]. XORSR: SR←SR^a[2:0]. No write-back.
  - Undefined opcode: NOP; flags unchanged; no write-back.
- **Reset:**
  - State → IDLE; wb_valid, wb_addr, wb_data → 0; SR → 3'b000.
  - in_ready is 0 while rst_n is low and 1 from the first cycle after release.
  - Reset asserted mid-operation abandons the operation immediately; no partial write-back is ever presented.

## Timing
- Accept at edge E0 (in_valid & in_ready).
  - SR updates at E1.
  - wb_valid is high from E1 until the handshake edge.
- Minimum occupancy per op:
  - 2 cycles for non-write-back ops.
  - 3 cycles with a single write-back.
  - 4 cycles for SWAP.
- wb_addr and wb_data are stable while wb_valid=1 and wb_ready=0; no combinational path from wb_ready to wb_*.
- in_ready is low from E0 until the cycle after the final write-back handshake.
- A new in_valid can be accepted in the IDLE cycle that follows.
- An op accepted after an ADC/SBC sees the SR written by the preceding op (no forwarding hazard, since ops are serialised).

## Structure
- alu_pkg holds:
  - widths WORD_W, HALF_W, REG_AW
  - opcode enum (NOT, AND, OR, XOR, SHL, SHR, ROTL, ROTR, SWAP, INC, DEC, ADD, ADC, SUB, SBC, EQ, GT, LT, GE, LE, LDSR, XORSR)
  - SR bit indices Z=0, S=1, C=2
  - state enum
- Sub-module alu_core, purely combinational:
  - inputs: op, mode, a, b, sr_in
  - outputs: res_a, res_b, sr_next, wb_cnt (0/1/2)
- alu_exec_stage owns the FSM, operand/result registers and SR.

## Test plan
- **ADD full-word overflow:** mode 1, a=0xFFFFF, b=0x00001, rd_a=3, wb_ready=1 → wb_valid at E1 with {3, 0x00000}; sr_out=3'b101 (Z, C); in_ready returns 1 two cycles after accept.
- **Half-word SUB with borrow:** mode 0, a=0x00003, b=0x00005 → wb_data=0x003FE, Z=0, S=1, C=1 (sr_out=3'b110).
- **SWAP with backpressure:** a=0x12345, b=0x0ABCD, rd_a=1, rd_b=2, wb_ready low for 3 cycles → {1, 0x0ABCD} held stable, then {2, 0x12345}; in_ready=0 throughout; sr_out unchanged.
- **ADC consumes carry:** after the ADD test (C=1), ADC a=0x00001, b=0x00001 → wb_data=0x00003, sr_out=3'b000.
- **Status-register ops:** LDSR a=0x00005 → sr_out=3'b101; then XORSR a=0x00003 → sr_out=3'b110; wb_valid never asserts.
- **Reset in WB_A:** drop rst_n while wb_valid=1 → wb_valid=0, sr_out=0 and wb_data=0 without waiting for a clock edge; in_ready=1 on the first cycle after release.
